// File: rtl/aes_pkg.sv
// Shared AES-128 constants, S-box table and helpers for the encryption core and key expansion.
package aes_pkg;

  localparam int NR      = 10;
  localparam int BLOCK_W = 128;
  localparam int KEY_W   = BLOCK_W * (NR + 1);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round key 0 sits in the most significant 128 bits of the bus.
  function automatic logic [BLOCK_W-1:0] rk(input logic [KEY_W-1:0] keys, input logic [3:0] r);
    return keys[KEY_W-1-BLOCK_W*int'(r) -: BLOCK_W];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup, one byte in and one byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = SBOX[a];

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption: one full round per clock, done pulses 10 cycles after an accepted start.
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_W-1:0]   expandedKeys,
  input  logic               start,
  input  logic [BLOCK_W-1:0] plaintext,
  output logic               busy,
  output logic               done,
  output logic [BLOCK_W-1:0] ciphertext
);

  fsm_t               fsm_q;
  fsm_t               fsm_d;
  logic [BLOCK_W-1:0] state_q;
  logic [3:0]         rnd;
  logic [BLOCK_W-1:0] sub;
  logic [BLOCK_W-1:0] shifted;
  logic [BLOCK_W-1:0] round_out;
  logic [BLOCK_W-1:0] final_out;

  // Byte i is row i%4, column i/4; row r rotates left by r columns.
  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return t;
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] t;
    logic [7:0]         a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      t[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      t[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      t[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      t[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return t;
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (
      .a (state_q[127-8*i -: 8]),
      .y (sub[127-8*i -: 8])
    );
  end

  assign shifted   = shift_rows(sub);
  assign round_out = mix_columns(shifted) ^ rk(expandedKeys, rnd);
  assign final_out = shifted ^ rk(expandedKeys, 4'(NR));

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (start) fsm_d = ROUND;
      ROUND:   if (rnd == 4'(NR - 1)) fsm_d = FINAL;
      FINAL:   fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= '0;
      rnd        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ciphertext <= '0;
    end else begin
      done <= 1'b0;
      unique case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q <= plaintext ^ rk(expandedKeys, 4'd0);
            rnd     <= 4'd1;
            busy    <= 1'b1;
          end
        end
        ROUND: begin
          state_q <= round_out;
          rnd     <= rnd + 4'd1;
        end
        FINAL: begin
          ciphertext <= final_out;
          done       <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: FIPS-197 vectors, handshake corners and a random regression against a byte-level model.
module tb_aes_encrypt_iter;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1407:0] keys;
  logic [127:0]  pt;
  logic          busy;
  logic          done;
  logic [127:0]  ct;

  int checks   = 0;
  int failures = 0;
  int done_total = 0;

  logic [7:0] sb [256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes_encrypt_iter dut (
    .clk          (clk),
    .rst          (rst),
    .expandedKeys (keys),
    .start        (start),
    .plaintext    (pt),
    .busy         (busy),
    .done         (done),
    .ciphertext   (ct)
  );

  always @(negedge clk) if (done === 1'b1) done_total++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] bus;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    bus = '0;
    for (int i = 0; i < 44; i++) bus[1407-32*i -: 32] = w[i];
    return bus;
  endfunction

  function automatic logic [127:0] model_enc(input logic [1407:0] bus, input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ bus[1407-8*i -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (rd < 10) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(t[4*c+k], coef[(k-r+4)%4]);
            s[4*c+r] = acc;
          end else begin
            s[4*c+r] = t[4*c+r];
          end
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ bus[1407-128*rd-8*i -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Returns once done is seen or the cycle budget runs out.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 30) begin
      if (busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic run_one(input string tag, input logic [127:0] exp);
    int lat, bcnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bcnt);
    chk({tag, "_latency"}, 128'(lat), 128'd10);
    chk({tag, "_busy_cycles"}, 128'(bcnt), 128'd10);
    chk({tag, "_ct"}, ct, exp);
    tick();
    chk({tag, "_done_pulse"}, 128'(done), 128'd0);
  endtask

  initial begin
    int lat, bcnt, d0;
    logic [7:0] b, r, s;
    logic [127:0] rk_, rp;

    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      s = b;
      r = b;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb[x] = s ^ 8'h63;
    end

    rst = 1'b1; start = 1'b0; keys = '0; pt = '0;
    tick(); tick();
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_ct", ct, 128'd0);
    rst = 1'b0;
    tick();

    keys = expand(C1_KEY); pt = C1_PT;
    run_one("c1", C1_CT);

    keys = expand(B_KEY); pt = B_PT;
    run_one("fipsb", B_CT);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("fipsb_hold", ct, B_CT);
    end

    // start held high; plaintext moves while busy and must not disturb the run
    keys = expand(C1_KEY); pt = C1_PT; start = 1'b1;
    tick();
    pt = B_PT;
    wait_done(lat, bcnt);
    chk("held_latency", 128'(lat), 128'd10);
    chk("held_busy_cycles", 128'(bcnt), 128'd10);
    chk("held_ct", ct, C1_CT);
    keys = expand(B_KEY);
    tick();
    start = 1'b0;
    chk("b2b_accept_busy", 128'(busy), 128'd1);
    wait_done(lat, bcnt);
    chk("b2b_latency", 128'(lat + 1), 128'd11);
    chk("b2b_ct", ct, B_CT);
    tick();

    keys = expand(C1_KEY); pt = C1_PT; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_ct", ct, 128'd0);
    d0 = done_total;
    repeat (15) tick();
    chk("abort_no_done", 128'(done_total - d0), 128'd0);
    run_one("after_abort", C1_CT);

    d0 = done_total;
    for (int n = 0; n < 1000; n++) begin
      rk_ = {$urandom, $urandom, $urandom, $urandom};
      rp  = {$urandom, $urandom, $urandom, $urandom};
      keys = expand(rk_);
      pt   = rp;
      run_one("rand", model_enc(keys, rp));
    end
    chk("rand_done_count", 128'(done_total - d0), 128'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
